// File: rtl/conversor_bcd.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3), fixed latency of N_BITS+1 cycles.
// Define CONVERSOR_BCD_SIGNO_EN to treat RES as two's complement and report its sign on NEG.
module conversor_bcd #(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned N_DIG  = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [N_BITS-1:0]    RES,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*N_DIG-1:0]   BCD,
  output logic                 NEG,
  output logic [3:0]           NDIG
);

  localparam int unsigned CntW = $clog2(N_BITS + 1);
  localparam int unsigned AccW = 4 * N_DIG;

  typedef enum logic [1:0] {IDLE, DESPLAZA, FIN} state_t;

  state_t            state;
  logic [AccW-1:0]   acc;
  logic [AccW-1:0]   acc_adj;
  logic [N_BITS-1:0] shreg;
  logic [N_BITS-1:0] mag;
  logic [CntW-1:0]   cnt;
  logic [3:0]        ndig_calc;

`ifdef CONVERSOR_BCD_SIGNO_EN
  logic neg_lat;

  // Negating the most negative value wraps to itself, which read as unsigned is |RES|.
  assign mag = RES[N_BITS-1] ? -RES : RES;
`else
  assign mag = RES;
  assign NEG = 1'b0;
`endif

  // Pre-shift correction: any digit >= 5 would overflow past 9 once doubled.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Position of the most significant non-zero digit; zero still reports one digit.
  always_comb begin
    ndig_calc = 4'd1;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (acc[4*i +: 4] != 4'd0) begin
        ndig_calc = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      BCD   <= '0;
      NDIG  <= 4'd1;
      acc   <= '0;
      shreg <= '0;
      cnt   <= '0;
`ifdef CONVERSOR_BCD_SIGNO_EN
      NEG     <= 1'b0;
      neg_lat <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            shreg <= mag;
            acc   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= DESPLAZA;
`ifdef CONVERSOR_BCD_SIGNO_EN
            neg_lat <= RES[N_BITS-1];
`endif
          end
        end
        DESPLAZA: begin
          {acc, shreg} <= {acc_adj, shreg} << 1;
          cnt          <= cnt + 1'b1;
          if (cnt == CntW'(N_BITS - 1)) begin
            state <= FIN;
          end
        end
        FIN: begin
          BCD   <= acc;
          NDIG  <= ndig_calc;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
`ifdef CONVERSOR_BCD_SIGNO_EN
          NEG <= neg_lat;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd.sv
// Directed self-checking bench for conversor_bcd; signed expectations follow CONVERSOR_BCD_SIGNO_EN.
module tb_conversor_bcd;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] RES;
  logic        BUSY;
  logic        DONE;
  logic [39:0] BCD;
  logic        NEG;
  logic [3:0]  NDIG;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cyc;
  int n_busy;
  int n_done;

  conversor_bcd dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .RES   (RES),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .BCD   (BCD),
    .NEG   (NEG),
    .NDIG  (NDIG)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Counts cycles (and BUSY cycles) from the current cycle until DONE, bounded.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    while (DONE !== 1'b1 && cyc < 80) begin
      busy_cnt += (BUSY === 1'b1) ? 1 : 0;
      tick();
      cyc++;
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] v, input logic [39:0] e_bcd,
                         input logic e_neg, input logic [3:0] e_ndig);
    START = 1'b1;
    RES   = v;
    tick();
    START = 1'b0;
    RES   = $urandom;
    wait_done(n_cyc, n_busy);
    check({tag, "_lat"}, 64'(n_cyc), 64'd33);
    check({tag, "_busy"}, 64'(n_busy), 64'd33);
    check({tag, "_bcd"}, 64'(BCD), 64'(e_bcd));
    check({tag, "_neg"}, 64'(NEG), 64'(e_neg));
    check({tag, "_ndig"}, 64'(NDIG), 64'(e_ndig));
    tick();
    check({tag, "_pulse"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    RES   = 32'hDEAD_BEEF;
    tick();
    tick();
    RST = 1'b0;
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_bcd", 64'(BCD), 64'd0);
    check("rst_neg", 64'(NEG), 64'd0);
    check("rst_ndig", 64'(NDIG), 64'd1);

    convert("zero", 32'd0, 40'h00_0000_0000, 1'b0, 4'd1);
    convert("dec", 32'd12345, 40'h00_0001_2345, 1'b0, 4'd5);
    convert("nine", 32'd9, 40'h00_0000_0009, 1'b0, 4'd1);
    convert("ten", 32'd10, 40'h00_0000_0010, 1'b0, 4'd2);
    convert("giga", 32'd1000000000, 40'h10_0000_0000, 1'b0, 4'd10);
`ifdef CONVERSOR_BCD_SIGNO_EN
    convert("ones", 32'hFFFF_FFFF, 40'h00_0000_0001, 1'b1, 4'd1);
    convert("minint", 32'h8000_0000, 40'h21_4748_3648, 1'b1, 4'd10);
    convert("neg42", 32'hFFFF_FFD6, 40'h00_0000_0042, 1'b1, 4'd2);
`else
    convert("ones", 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0, 4'd10);
    convert("msb", 32'h8000_0000, 40'h21_4748_3648, 1'b0, 4'd10);
`endif

    // START while busy must be ignored and never queued.
    START = 1'b1;
    RES   = 32'd7;
    tick();
    START = 1'b0;
    repeat (4) tick();
    START = 1'b1;
    RES   = 32'd99;
    tick();
    START = 1'b0;
    wait_done(n_cyc, n_busy);
    check("busy_lat", 64'(n_cyc), 64'd28);
    check("busy_bcd", 64'(BCD), 64'h00_0000_0007);
    n_done = 0;
    tick();
    for (int i = 0; i < 45; i++) begin
      n_done += (DONE === 1'b1) ? 1 : 0;
      tick();
    end
    check("busy_nodone", 64'(n_done), 64'd0);
    check("busy_idle", 64'(BUSY), 64'd0);

    // Reset mid-conversion aborts with no DONE.
    START = 1'b1;
    RES   = 32'd12345;
    tick();
    START = 1'b0;
    repeat (9) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_bcd", 64'(BCD), 64'd0);
    check("abort_ndig", 64'(NDIG), 64'd1);
    check("abort_neg", 64'(NEG), 64'd0);
    n_done = 0;
    for (int i = 0; i < 45; i++) begin
      n_done += (DONE === 1'b1) ? 1 : 0;
      tick();
    end
    check("abort_nodone", 64'(n_done), 64'd0);
    convert("after_rst", 32'd42, 40'h00_0000_0042, 1'b0, 4'd2);

    // START held high: FIN ignores it, the following IDLE cycle accepts it.
    START = 1'b1;
    RES   = 32'd10;
    tick();
    wait_done(n_cyc, n_busy);
    check("hold_lat", 64'(n_cyc), 64'd33);
    check("hold_idle", 64'(BUSY), 64'd0);
    tick();
    check("hold_restart", 64'(BUSY), 64'd1);
    START = 1'b0;
    wait_done(n_cyc, n_busy);
    check("hold_lat2", 64'(n_cyc), 64'd33);
    check("hold_bcd", 64'(BCD), 64'h00_0000_0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 The block SHALL have parameter N_BITS, default 32, giving the binary input width.
REQ-002 The block SHALL have parameter N_DIG, default 10, giving the number of BCD output digits; integrator guarantees 10^N_DIG > 2^N_BITS.
REQ-003 Port CLK SHALL be an input, 1 bit: the single system clock, rising-edge active.
REQ-004 Port RST SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-005 Port START SHALL be an input, 1 bit: request to convert RES, sampled at the rising edge.
REQ-006 Port RES SHALL be an input, N_BITS wide: ALU result to convert, sampled only when START is accepted.
REQ-007 Port BUSY SHALL be an output, 1 bit: high while a conversion is in progress.
REQ-008 Port DONE SHALL be an output, 1 bit: one-cycle pulse marking that new BCD/NEG/NDIG values are valid.
REQ-009 Port BCD SHALL be an output, 4*N_DIG wide: the magnitude as packed BCD, with the least significant digit in bits [3:0].
REQ-010 Port NEG SHALL be an output, 1 bit: sign of the converted value (see Configuration).
REQ-011 Port NDIG SHALL be an output, 4 bits: count of significant digits, 1..N_DIG (value 0 counts as 1 digit).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DESPLAZA and FIN.
REQ-013 In IDLE with START=1, at the rising edge the block SHALL latch the magnitude of RES into the shift register, clear the BCD accumulator and the bit counter, and go to DESPLAZA.
REQ-014 In DESPLAZA, every cycle the block SHALL add 3 to each accumulator digit that is >=5, then shift {accumulator, shift register} left by 1 and increment the counter.
REQ-015 After exactly N_BITS shifts the FSM SHALL go to FIN.
REQ-016 In FIN the block SHALL load BCD, NEG and NDIG from the accumulator, assert DONE for that one cycle, and return to IDLE.
REQ-017 The latency SHALL be fixed: START sampled at edge k gives DONE=1 in the cycle after edge k+N_BITS+1 (33 cycles for the default).
REQ-018 BUSY SHALL be 1 from the cycle after START acceptance through the FIN cycle inclusive, and 0 otherwise.
REQ-019 START while BUSY=1 SHALL be ignored; it is neither queued nor allowed to alter the conversion in progress.
REQ-020 START asserted in the FIN cycle SHALL be ignored; START held high continuously SHALL start a new conversion on the first IDLE cycle.
REQ-021 BCD, NEG and NDIG SHALL hold their previous values until the next FIN cycle and SHALL never show partial accumulator contents.
REQ-022 RES SHALL be don't-care except at the START acceptance edge.

Reset
REQ-023 With RST=1 at a rising edge, the FSM SHALL go to IDLE, and BUSY=0, DONE=0, BCD=0, NEG=0 and NDIG=1.
REQ-024 RST SHALL take priority over START and over every FSM state.
REQ-025 A reset during DESPLAZA or FIN SHALL abort the conversion with no DONE pulse.
REQ-026 The first conversion after reset SHALL behave identically to any later one.

Configuration
REQ-027 When macro CONVERSOR_BCD_SIGNO_EN is defined, RES SHALL be two's complement, the latched magnitude SHALL be |RES| (0x80000000 -> 2147483648), and NEG SHALL equal RES[N_BITS-1] captured at START.
REQ-028 When CONVERSOR_BCD_SIGNO_EN is undefined, RES SHALL be unsigned, the magnitude SHALL equal RES, NEG SHALL be constant 0, and no negation logic SHALL be synthesised.

Verification
REQ-029 Test zero: reset, then RES=0 with START for 1 cycle -> BUSY for 33 cycles, DONE at +33, BCD=0x0000000000, NEG=0, NDIG=1.
REQ-030 Test decimal: RES=12345 -> BCD=0x0000012345, NDIG=5, NEG=0, in both builds.
REQ-031 Test all-ones: RES=0xFFFFFFFF -> without the macro BCD=0x4294967295, NDIG=10, NEG=0; with CONVERSOR_BCD_SIGNO_EN BCD=0x0000000001, NEG=1, NDIG=1.
REQ-032 Test minimum signed (signed build): RES=0x80000000 -> BCD=0x2147483648, NEG=1, NDIG=10.
REQ-033 Test busy: START for RES=7, then START with RES=99 at cycle +5 -> a single DONE at +33 with BCD=0x0000000007.
REQ-034 Test reset mid-conversion: RST pulsed at cycle +10 -> no DONE, all outputs at reset values; the next START with RES=42 gives BCD=0x0000000042 at +33.
